lc3_pipeline_ctrl: RTL and testbench

Pipeline controller for the LC3 core. It sequences the fetch, decode, execute and writeback enables. It stalls the pipe for data-memory accesses and resolves BR/JMP from the execute-stage instruction (`IR_Exec`, `NZP`) that the execute stage publishes on its output bus. It also raises ALU bypass selects for back-to-back register dependencies.

---
 rtl/lc3_pipeline_ctrl_if.sv | 31 +++
 rtl/lc3_pipeline_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lc3_pipeline_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lc3_pipeline_ctrl_if.sv
// Control/status bundle between the LC3 datapath stages and the pipeline controller.
// The master view is the datapath side; the slave view is the controller.
interface lc3_pipeline_ctrl_if;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  NZP;
    logic [2:0]  psr;
    logic        enable_fetch;
    logic        enable_updatePC;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic [1:0]  mem_state;

    modport master (
        output complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        input  enable_fetch, enable_updatePC, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2, mem_state
    );

    modport slave (
        input  complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        output enable_fetch, enable_updatePC, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2, mem_state
    );
endinterface

// File: rtl/lc3_pipeline_ctrl.sv
// LC3 pipeline sequencer: refill, run, branch flush and data-memory stall; enables are combinational.
// Stalls on instruction fetch (complete_instr) and on data memory (complete_data); reset forces idle outputs at once.
module lc3_pipeline_ctrl #(
    parameter int FILL_STAGES = 4
) (
    input  logic                clock,
    input  logic                reset,
    lc3_pipeline_ctrl_if.slave  bus
);
    localparam int CW = $clog2(FILL_STAGES + 1);

    typedef enum logic [2:0] {
        ST_FILL, ST_RUN, ST_B1, ST_B2, ST_B3, ST_MEM
    } state_t;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_IND   = 2'd1;
    localparam logic [1:0] MS_WRITE = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_LEA = 4'b1110;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
    endfunction

    function automatic logic is_ldst(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI) ||
               (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    function automatic logic [1:0] mem_entry(input logic [3:0] op);
        if ((op == OP_LD) || (op == OP_LDR))
            return MS_READ;
        else if ((op == OP_LDI) || (op == OP_STI))
            return MS_IND;
        else
            return MS_WRITE;
    endfunction

    function automatic logic uses_sr1(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
               (op == OP_LDR) || (op == OP_STR) || (op == OP_JMP);
    endfunction

    logic [3:0] op_dec;
    logic [3:0] op_exe;
    assign op_dec = bus.IR[15:12];
    assign op_exe = bus.IR_Exec[15:12];

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mem_state_q, mem_state_d;
    logic          exec_valid_q;

    logic fetch_c, updpc_c, dec_c, exe_c, wb_c, br_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            cnt_q        <= CW'(1);
            mem_state_q  <= MS_IDLE;
            exec_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_state_q  <= mem_state_d;
            exec_valid_q <= exe_c;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_state_d = mem_state_q;
        fetch_c     = 1'b0;
        updpc_c     = 1'b0;
        dec_c       = 1'b0;
        exe_c       = 1'b0;
        wb_c        = 1'b0;
        br_c        = 1'b0;
        case (state_q)
            ST_FILL: begin
                fetch_c = 1'b1;
                updpc_c = 1'b1;
                dec_c   = (cnt_q >= CW'(2));
                exe_c   = (cnt_q >= CW'(3));
                wb_c    = (cnt_q >= CW'(4));
                if (cnt_q == CW'(FILL_STAGES)) begin
                    state_d = ST_RUN;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                fetch_c = 1'b1;
                updpc_c = bus.complete_instr;
                dec_c   = bus.complete_instr;
                exe_c   = bus.complete_instr;
                wb_c    = bus.complete_instr;
                // A memory op already in execute outranks a branch waiting in decode; IR is held meanwhile.
                if (exec_valid_q && is_ldst(op_exe)) begin
                    state_d     = ST_MEM;
                    mem_state_d = mem_entry(op_exe);
                end else if (dec_c && is_ctrl(op_dec)) begin
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                exe_c   = 1'b1;
                wb_c    = 1'b1;
                state_d = ST_B2;
            end
            ST_B2: begin
                updpc_c = 1'b1;
                br_c    = (op_exe == OP_JMP) ||
                          ((op_exe == OP_BR) && |(bus.NZP & bus.psr));
                state_d = ST_B3;
            end
            ST_B3: begin
                state_d = ST_FILL;
                cnt_d   = CW'(1);
            end
            ST_MEM: begin
                case (mem_state_q)
                    MS_READ: if (bus.complete_data) begin
                        wb_c        = 1'b1;
                        state_d     = ST_RUN;
                        mem_state_d = MS_IDLE;
                    end
                    MS_IND: if (bus.complete_data) begin
                        mem_state_d = (op_exe == OP_LDI) ? MS_READ : MS_WRITE;
                    end
                    MS_WRITE: if (bus.complete_data) begin
                        state_d     = ST_RUN;
                        mem_state_d = MS_IDLE;
                    end
                    default: begin
                        state_d     = ST_RUN;
                        mem_state_d = MS_IDLE;
                    end
                endcase
            end
            default: begin
                state_d     = ST_FILL;
                cnt_d       = CW'(1);
                mem_state_d = MS_IDLE;
            end
        endcase
    end

    // Enables are gated by reset so a mid-cycle reset idles the pipe without waiting for an edge.
    assign bus.enable_fetch     = reset & fetch_c;
    assign bus.enable_updatePC  = reset & updpc_c;
    assign bus.enable_decode    = reset & dec_c;
    assign bus.enable_execute   = reset & exe_c;
    assign bus.enable_writeback = reset & wb_c;
    assign bus.br_taken         = reset & br_c;
    assign bus.mem_state        = mem_state_q;

    logic fwd_ok;
    assign fwd_ok = reset && (state_q == ST_RUN) && exec_valid_q && is_alu(op_exe);

    assign bus.bypass_alu_1 = fwd_ok && uses_sr1(op_dec) &&
                              (bus.IR[8:6] == bus.IR_Exec[11:9]);
    assign bus.bypass_alu_2 = fwd_ok && ((op_dec == OP_ADD) || (op_dec == OP_AND)) &&
                              !bus.IR[5] && (bus.IR[2:0] == bus.IR_Exec[11:9]);

    logic unused_bits;
    assign unused_bits = ^{bus.IR[11:9], bus.IR[4:3], bus.IR_Exec[8:0]};
endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// Directed bench for lc3_pipeline_ctrl: refill, stalls, memory sub-states, branches, bypass, reset.
module tb_lc3_pipeline_ctrl;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    lc3_pipeline_ctrl_if bif();

    lc3_pipeline_ctrl #(.FILL_STAGES(4)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] en_v();
        return {bif.enable_fetch, bif.enable_updatePC, bif.enable_decode,
                bif.enable_execute, bif.enable_writeback};
    endfunction

    function automatic logic [1:0] byp_v();
        return {bif.bypass_alu_1, bif.bypass_alu_2};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Checks the four refill cycles; returns positioned in the first RUN cycle.
    task automatic fill_seq(input string tag);
        logic [4:0] p;
        for (int i = 0; i < 4; i++) begin
            p = {2'b11, (i >= 1), (i >= 2), (i >= 3)};
            check($sformatf("%s_en%0d", tag, i + 1), 16'(en_v()), 16'(p));
            check($sformatf("%s_byp%0d", tag, i + 1), 16'(byp_v()), 16'h0);
            nxt();
            #1;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bif.complete_instr = 1'b1;
        bif.complete_data  = 1'b0;
        bif.IR      = 16'h1000;
        bif.IR_Exec = 16'h1000;
        bif.NZP     = 3'b000;
        bif.psr     = 3'b000;

        nxt(); nxt(); #1;
        check("rst_en",  16'(en_v()), 16'h0);
        check("rst_br",  16'(bif.br_taken), 16'h0);
        check("rst_ms",  16'(bif.mem_state), 16'h3);
        check("rst_byp", 16'(byp_v()), 16'h0);

        nxt(); rst_n = 1'b1; #1;
        fill_seq("fill_a");
        check("run_en",  16'(en_v()), 16'h1F);
        check("run_byp", 16'(byp_v()), 16'h3);

        nxt(); bif.complete_instr = 1'b0; #1;
        check("stall_en", 16'(en_v()), 16'h10);

        nxt(); bif.complete_instr = 1'b1; bif.IR_Exec = 16'h1261; bif.IR = 16'h1441; #1;
        check("byp_noval", 16'(byp_v()), 16'h0);
        nxt(); #1;
        check("byp_both", 16'(byp_v()), 16'h3);
        nxt(); bif.IR = 16'h1461; #1;
        check("byp_imm", 16'(byp_v()), 16'h2);

        // LD with completion on the third MEM cycle
        nxt(); bif.IR = 16'h1000; bif.IR_Exec = 16'h2202; #1;
        check("ld_run_en",  16'(en_v()), 16'h1F);
        check("ld_run_byp", 16'(byp_v()), 16'h0);
        check("ld_run_ms",  16'(bif.mem_state), 16'h3);
        nxt(); #1;
        check("ld_m1_ms", 16'(bif.mem_state), 16'h0);
        check("ld_m1_en", 16'(en_v()), 16'h0);
        nxt(); #1;
        check("ld_m2_ms", 16'(bif.mem_state), 16'h0);
        check("ld_m2_en", 16'(en_v()), 16'h0);
        nxt(); bif.complete_data = 1'b1; #1;
        check("ld_m3_ms", 16'(bif.mem_state), 16'h0);
        check("ld_m3_en", 16'(en_v()), 16'h01);
        nxt(); bif.complete_data = 1'b0; bif.IR_Exec = 16'h1000; #1;
        check("ld_ret_ms", 16'(bif.mem_state), 16'h3);
        check("ld_ret_en", 16'(en_v()), 16'h1F);

        // STI: indirect then write, completion on the entry cycle
        nxt(); bif.IR_Exec = 16'hB401; #1;
        check("sti_run_en", 16'(en_v()), 16'h1F);
        nxt(); bif.complete_data = 1'b1; #1;
        check("sti_ind_ms", 16'(bif.mem_state), 16'h1);
        check("sti_ind_en", 16'(en_v()), 16'h0);
        nxt(); #1;
        check("sti_wr_ms", 16'(bif.mem_state), 16'h2);
        check("sti_wr_en", 16'(en_v()), 16'h0);
        nxt(); bif.complete_data = 1'b0; bif.IR_Exec = 16'h1000; #1;
        check("sti_ret_ms", 16'(bif.mem_state), 16'h3);
        check("sti_ret_en", 16'(en_v()), 16'h1F);

        // BRz taken
        bif.IR = 16'h0402; bif.NZP = 3'b010; bif.psr = 3'b010; #1;
        nxt(); bif.IR_Exec = 16'h0402; bif.IR = 16'h1000; #1;
        check("brt_b1_en", 16'(en_v()), 16'h03);
        check("brt_b1_br", 16'(bif.br_taken), 16'h0);
        nxt(); #1;
        check("brt_b2_en", 16'(en_v()), 16'h08);
        check("brt_b2_br", 16'(bif.br_taken), 16'h1);
        nxt(); #1;
        check("brt_b3_en", 16'(en_v()), 16'h0);
        check("brt_b3_br", 16'(bif.br_taken), 16'h0);
        nxt(); bif.IR_Exec = 16'h1000; #1;
        fill_seq("fill_b");

        // BRz not taken
        bif.IR = 16'h0402; bif.psr = 3'b001; #1;
        nxt(); bif.IR_Exec = 16'h0402; bif.IR = 16'h1000; #1;
        check("brn_b1_en", 16'(en_v()), 16'h03);
        nxt(); #1;
        check("brn_b2_en", 16'(en_v()), 16'h08);
        check("brn_b2_br", 16'(bif.br_taken), 16'h0);
        nxt(); nxt(); bif.IR_Exec = 16'h1000; #1;
        fill_seq("fill_c");

        // Load in execute and branch in decode together: memory first, branch afterwards
        bif.IR_Exec = 16'h2202; bif.IR = 16'h0402; #1;
        nxt(); bif.complete_data = 1'b1; #1;
        check("prio_mem_ms", 16'(bif.mem_state), 16'h0);
        check("prio_mem_en", 16'(en_v()), 16'h01);
        nxt(); bif.complete_data = 1'b0; bif.IR_Exec = 16'h1000; #1;
        check("prio_ret_ms", 16'(bif.mem_state), 16'h3);
        check("prio_ret_en", 16'(en_v()), 16'h1F);
        nxt(); bif.IR_Exec = 16'h0402; #1;
        check("prio_b1_en", 16'(en_v()), 16'h03);
        nxt(); nxt(); nxt(); bif.IR = 16'h1000; bif.IR_Exec = 16'h1000; #1;
        fill_seq("fill_d");

        // Reset asserted during the read sub-state
        bif.IR_Exec = 16'h2202; #1;
        nxt(); #1;
        check("rmem_ms", 16'(bif.mem_state), 16'h0);
        nxt(); bif.complete_data = 1'b1; rst_n = 1'b0; #1;
        check("rmem_en", 16'(en_v()), 16'h0);
        check("rmem_ms_rst", 16'(bif.mem_state), 16'h3);
        check("rmem_br", 16'(bif.br_taken), 16'h0);
        nxt(); bif.complete_data = 1'b0; bif.IR_Exec = 16'h1000; rst_n = 1'b1; #1;
        check("refill1_en", 16'(en_v()), 16'h18);
        nxt(); #1;
        check("refill2_en", 16'(en_v()), 16'h1C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
